clk_div_gen: RTL and testbench
==============================

# clk_div_gen

Parametrised, single-clock successor to the PHY clock generator. It derives a bank of phase-aligned divided clocks, one-cycle edge strobes and a runtime-selectable divided clock from `clk_32f`. All state is updated on `clk_32f` with no ripple stages, so every output is registered in one clock domain. It feeds the serializer/deserializer and byte-striping logic that need `clk_f`, `clk_2f` and `clk_4f`, plus enable-style strobes.

## Interface
Parameters:
- `STAGES`, default 5: divider depth. `clk_div[i]` runs at f(`clk_32f`)/2^(i+1). Legal range 1..16.
- `SEL_W`, default `$clog2(STAGES)` (minimum 1): width of the `sel` input.

Ports:
- `clk_32f`  input  1  sole clock, rising edge.
- `reset_clk`  input  1  reset; synchronous, active-low.
- `en`  input  1  count enable. When low, the divider freezes.
- `align`  input  1  synchronous phase restart, one-cycle pulse.
- `sel`  input  `SEL_W`  index of the stage routed to `clk_sel`.
- `clk_div`  output  `STAGES`  divided clocks. With the default of 5: [2]=`clk_4f`, [3]=`clk_2f`, [4]=`clk_f`.
- `rise_stb`  output  `STAGES`  bit i is high for the first `clk_32f` cycle in which `clk_div[i]` is high.
- `fall_stb`  output  `STAGES`  bit i is high for the first cycle in which `clk_div[i]` is low after being high.
- `clk_sel`  output  1  the selected divided clock.
- `sel_act`  output  `SEL_W`  the selection index currently in effect.
- `locked`  output  1  phase valid. Set on the first full wrap.

## Operation
- Core counter `cnt[STAGES-1:0]`:
  - Increments by 1 modulo 2^STAGES on each edge where `en`=1.
  - `clk_div` equals `cnt`, bit-for-bit, from the register.
- Strobes, registered and computed from `cnt_next`:
  - `rise_stb[i]` is 1 when the counter advances and `cnt_next[i:0]` == 1<<i.
  - `fall_stb[i]` is 1 when the counter advances and `cnt_next[i:0]` == 0.
  - Both are 0 on any edge where the counter does not advance.
- Selection:
  - `sel` is sampled every cycle into `sel_pend`.
  - `sel_act` loads `sel_pend` only at a wrap (`cnt` all ones and advancing), on `align`, or on reset.
  - At a wrap every `clk_div` bit goes low together, so `clk_sel` has no runt pulse.
  - `clk_sel` is registered as `cnt_next[sel_act_next]`.
  - A `sel` value ≥ STAGES is clamped to STAGES-1.
- `locked`:
  - Cleared by reset or `align`.
  - Set on the edge where the counter wraps.
  - Once set, stays 1 until the next reset or `align`.
- `align`:
  - `cnt`=0, so all `clk_div` bits are 0. This may shorten the current high or low phase, which is accepted.
  - `clk_sel`=0, `rise_stb`=`fall_stb`=0, `locked`=0.
  - `sel_act` loads `sel`.
- Priority order: `reset_clk` low > `align` > `en`.
  - `align` acts even when `en`=0.
- Reset (`reset_clk`=0 at an edge):
  - `cnt`, `clk_div`, `rise_stb`, `fall_stb`, `clk_sel` and `locked` all become 0.
  - `sel_act` and `sel_pend` load `sel`, clamped.
  - Applies at any point, including mid-period. No partial state survives.

## Timing
- Latency from `cnt` update to outputs is 0: all outputs are registered in the same edge as `cnt`.
- First edge after `reset_clk` returns to 1 with `en`=1:
  - `cnt`=1, `clk_div[0]`=1, `rise_stb` = 0…01.
- Steady state: `clk_div[i]` is high for 2^i cycles and low for 2^i cycles.
- A `sel` change takes effect at the next wrap. Worst case is 2^STAGES cycles.
- `locked` rises 2^STAGES edges after reset release, when `en` is held at 1.
- `en` low for k cycles stretches every period by exactly k cycles. No strobes are issued while frozen.

## Structure
- Shared PHY package holds:
  - `clk_div_gen` default constants: `CLKGEN_STAGES`=5.
  - Named indices `IDX_CLK_4F`=2, `IDX_CLK_2F`=3, `IDX_CLK_F`=4.
- No sub-module. One counter process plus one select/lock process is the natural split inside the module.
- A legacy wrapper that maps `clk_div[4:2]` to `clk_f`/`clk_2f`/`clk_4f` lives outside this block.

## Test plan
- Reset release, `en`=1, STAGES=5 -> `clk_div[4]` has period 32 cycles with 16 high. `rise_stb[4]` pulses at cycles 16, 48, 80. `locked` rises at cycle 32.
- `sel` changes from 4 to 2 at cycle 40 -> `sel_act` holds 4 until the wrap at cycle 64, then becomes 2. `clk_sel` gives a period of 8 from cycle 64, with no pulse shorter than 4 cycles.
- `en` low for cycles 10–14 -> `cnt` holds at 10 (binary 01010). Strobes are all 0 during the freeze. `clk_div[4]` first rises at cycle 21.
- `align` at cycle 20 with `en`=0 -> next cycle `cnt`=0, `locked`=0, `sel_act`=`sel`. `locked` sets again 32 cycles after counting resumes.
- `reset_clk` low at `cnt`=27 -> next edge all outputs are 0. After release the sequence restarts exactly as in the first scenario.
- `sel`=7 with STAGES=5 -> `sel_act`=4 and `clk_sel` matches `clk_div[4]`.

Source files
------------

// File: rtl/clk_div_gen_pkg.sv
// Shared PHY clock-generation constants: default divider depth and the
// named stage indices used by the serializer and byte-striping logic.
package clk_div_gen_pkg;

   localparam int CLKGEN_STAGES = 5;

   localparam int IDX_CLK_4F = 2;
   localparam int IDX_CLK_2F = 3;
   localparam int IDX_CLK_F  = 4;

endpackage

// File: rtl/clk_div_gen.sv
// Single-domain binary divider bank on clk_32f with edge strobes, a
// wrap-synchronised selectable output and a phase-lock indicator.
module clk_div_gen
   import clk_div_gen_pkg::*;
#(
   parameter int STAGES = CLKGEN_STAGES,
   parameter int SEL_W  = (STAGES > 1) ? $clog2(STAGES) : 1
) (
   input  logic              clk_32f,
   input  logic              reset_clk,
   input  logic              en,
   input  logic              align,
   input  logic [SEL_W-1:0]  sel,
   output logic [STAGES-1:0] clk_div,
   output logic [STAGES-1:0] rise_stb,
   output logic [STAGES-1:0] fall_stb,
   output logic              clk_sel,
   output logic [SEL_W-1:0]  sel_act,
   output logic              locked
);

   logic [STAGES-1:0] cnt;
   logic [STAGES-1:0] cnt_next;
   logic [STAGES-1:0] rise_next;
   logic [STAGES-1:0] fall_next;
   logic [SEL_W-1:0]  sel_pend;
   logic [SEL_W-1:0]  sel_clamped;
   logic [SEL_W-1:0]  sel_act_next;
   logic              adv;
   logic              wrap;

   function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
      return (int'(s) >= STAGES) ? SEL_W'(STAGES - 1) : s;
   endfunction

   always_comb begin
      adv          = en & ~align;
      wrap         = adv & (cnt == '1);
      cnt_next     = align ? '0 : (adv ? cnt + STAGES'(1) : cnt);
      sel_clamped  = clamp_sel(sel);
      sel_act_next = align ? sel_clamped : (wrap ? sel_pend : sel_act);
      rise_next    = '0;
      fall_next    = '0;
      // Stage i masks off the bits above it: rise when low bits read 1<<i, fall on all-zero.
      for (int unsigned i = 0; i < STAGES; i++) begin
         rise_next[i] = adv &&
            ((cnt_next & ((STAGES'(1) << (i + 1)) - STAGES'(1))) == (STAGES'(1) << i));
         fall_next[i] = adv &&
            ((cnt_next & ((STAGES'(1) << (i + 1)) - STAGES'(1))) == '0);
      end
   end

   always_ff @(posedge clk_32f) begin
      if (!reset_clk) begin
         cnt      <= '0;
         rise_stb <= '0;
         fall_stb <= '0;
      end else begin
         cnt      <= cnt_next;
         rise_stb <= rise_next;
         fall_stb <= fall_next;
      end
   end

   always_ff @(posedge clk_32f) begin
      if (!reset_clk) begin
         sel_pend <= sel_clamped;
         sel_act  <= sel_clamped;
         clk_sel  <= 1'b0;
         locked   <= 1'b0;
      end else begin
         sel_pend <= sel_clamped;
         sel_act  <= sel_act_next;
         clk_sel  <= cnt_next[sel_act_next];
         if (align)
            locked <= 1'b0;
         else if (wrap)
            locked <= 1'b1;
      end
   end

   assign clk_div = cnt;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen at the default depth of 5 stages.
module tb_clk_div_gen;
   import clk_div_gen_pkg::*;

   localparam int STAGES = CLKGEN_STAGES;
   localparam int SEL_W  = 3;

   logic              clk_32f = 1'b0;
   logic              reset_clk;
   logic              en;
   logic              align;
   logic [SEL_W-1:0]  sel;
   logic [STAGES-1:0] clk_div;
   logic [STAGES-1:0] rise_stb;
   logic [STAGES-1:0] fall_stb;
   logic              clk_sel;
   logic [SEL_W-1:0]  sel_act;
   logic              locked;

   int n_tests = 0;
   int n_fail  = 0;

   clk_div_gen #(.STAGES(STAGES), .SEL_W(SEL_W)) dut (
      .clk_32f  (clk_32f),
      .reset_clk(reset_clk),
      .en       (en),
      .align    (align),
      .sel      (sel),
      .clk_div  (clk_div),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb),
      .clk_sel  (clk_sel),
      .sel_act  (sel_act),
      .locked   (locked)
   );

   always #5 clk_32f = ~clk_32f;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_32f);
      #1;
   endtask

   task automatic do_reset(input logic [SEL_W-1:0] s);
      reset_clk = 1'b0;
      en        = 1'b1;
      align     = 1'b0;
      sel       = s;
      step();
      step();
      reset_clk = 1'b1;
   endtask

   int rise4_q[$];
   int lock_edge;
   int high4;
   int stb_seen;
   int hit;

   initial begin
      reset_clk = 1'b0;
      en        = 1'b0;
      align     = 1'b0;
      sel       = 3'd4;

      // Reset state
      do_reset(3'd4);
      check("rst_cnt",     int'(clk_div),  0);
      check("rst_rise",    int'(rise_stb), 0);
      check("rst_fall",    int'(fall_stb), 0);
      check("rst_clk_sel", int'(clk_sel),  0);
      check("rst_locked",  int'(locked),   0);
      check("rst_sel_act", int'(sel_act),  4);

      // Free run from release; sel changes 4->2 after edge 40
      lock_edge = -1;
      high4     = 0;
      for (int n = 1; n <= 80; n++) begin
         step();
         if (n == 1) begin
            check("e1_cnt",  int'(clk_div),  1);
            check("e1_rise", int'(rise_stb), 1);
            check("e1_fall", int'(fall_stb), 0);
         end
         if (n == 27) check("e27_cnt", int'(clk_div), 27);
         if (n == 32) check("e32_fall", int'(fall_stb), 31);
         if (n <= 32 && clk_div[IDX_CLK_F]) high4++;
         if (rise_stb[IDX_CLK_F]) rise4_q.push_back(n);
         if (locked && lock_edge < 0) lock_edge = n;
         if (n == 40) sel = 3'd2;
         if (n == 63) begin
            check("e63_sel_act", int'(sel_act), 4);
            check("e63_clk_sel", int'(clk_sel), 1);
         end
         if (n == 64) begin
            check("e64_sel_act", int'(sel_act), 2);
            check("e64_clk_sel", int'(clk_sel), 0);
         end
         if (n == 67) check("e67_clk_sel", int'(clk_sel), 0);
         if (n == 68) check("e68_clk_sel", int'(clk_sel), 1);
         if (n == 71) check("e71_clk_sel", int'(clk_sel), 1);
         if (n == 72) check("e72_clk_sel", int'(clk_sel), 0);
      end
      check("clk_f_high_cycles", high4, 16);
      check("lock_edge", lock_edge, 32);
      check("rise4_count", rise4_q.size(), 3);
      if (rise4_q.size() == 3) begin
         check("rise4_0", rise4_q[0], 16);
         check("rise4_1", rise4_q[1], 48);
         check("rise4_2", rise4_q[2], 80);
      end

      // Freeze: en low for five edges after cnt reaches 10
      do_reset(3'd4);
      for (int n = 1; n <= 10; n++) step();
      check("frz_pre_cnt", int'(clk_div), 10);
      en = 1'b0;
      stb_seen = 0;
      for (int n = 11; n <= 15; n++) begin
         step();
         stb_seen = stb_seen | int'(rise_stb) | int'(fall_stb);
      end
      check("frz_cnt", int'(clk_div), 10);
      check("frz_stb", stb_seen, 0);
      en  = 1'b1;
      hit = -1;
      for (int n = 16; n <= 60 && hit < 0; n++) begin
         step();
         if (n == 16) check("frz_resume_rise", int'(rise_stb), 1);
         if (clk_div[IDX_CLK_F]) hit = n;
      end
      check("frz_clk_f_rise_edge", hit, 21);

      // Align while frozen, after lock has been reached
      do_reset(3'd4);
      for (int n = 1; n <= 40; n++) step();
      check("pre_align_locked", int'(locked), 1);
      en    = 1'b0;
      align = 1'b1;
      sel   = 3'd3;
      step();
      align = 1'b0;
      check("al_cnt",     int'(clk_div),  0);
      check("al_locked",  int'(locked),   0);
      check("al_sel_act", int'(sel_act),  3);
      check("al_clk_sel", int'(clk_sel),  0);
      check("al_stb",     int'(rise_stb) | int'(fall_stb), 0);
      en = 1'b1;
      for (int n = 1; n <= 32; n++) begin
         step();
         if (n == 27) check("al_cnt27", int'(clk_div), 27);
         if (n == 31) check("al_locked31", int'(locked), 0);
         if (n == 32) check("al_locked32", int'(locked), 1);
      end

      // Reset mid-period at cnt=27
      for (int n = 1; n <= 27; n++) step();
      check("pre_rst_cnt", int'(clk_div), 27);
      reset_clk = 1'b0;
      step();
      check("mr_out", int'(clk_div) | int'(rise_stb) | int'(fall_stb) |
            int'(clk_sel) | int'(locked), 0);
      reset_clk = 1'b1;
      for (int n = 1; n <= 32; n++) begin
         step();
         if (n == 1)  check("mr_e1_rise", int'(rise_stb), 1);
         if (n == 16) check("mr_e16_rise", int'(rise_stb), 16);
         if (n == 31) check("mr_locked31", int'(locked), 0);
         if (n == 32) check("mr_locked32", int'(locked), 1);
      end

      // Out-of-range select clamps to the top stage
      do_reset(3'd7);
      check("clamp_sel_act", int'(sel_act), 4);
      for (int n = 1; n <= 32; n++) begin
         step();
         if (n == 15) check("clamp_e15", int'(clk_sel), 0);
         if (n == 16) check("clamp_e16", int'(clk_sel), 1);
         if (n == 31) check("clamp_e31", int'(clk_sel), 1);
         if (n == 32) check("clamp_e32", int'(clk_sel), 0);
      end
      check("clamp_sel_act_wrap", int'(sel_act), 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
